// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction-cache responder.
//   word_t      : 32-bit machine word used on every datapath/memory bus.
//   icachef_t   : fetch-address split (tag/idx/bytoff) for the 16-frame build.
//                 The RTL derives its field widths from SETS locally, so this
//                 struct is a convenience view for other code and the bench.
package icache_responder_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;

  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_responder_if.sv
// Bundle of the two buses the instruction cache sits between.
//   Datapath side : imemREN/imemaddr in, ihit/imemload out.
//   Arbiter side  : iREN/iaddr out, iwait/iload in.
// Handshake: the datapath holds imemREN/imemaddr until it sees ihit=1 in the
// same cycle; imemload is valid only while ihit=1. Toward the arbiter, iREN
// acts as valid and !iwait as ready: a fill transfers on the single cycle with
// iREN && !iwait, and iaddr stays stable from iREN rising until that cycle.
// Modports:
//   slave  : the cache (this block's view)
//   master : the surrounding environment (datapath + arbiter)
interface icache_responder_if
  import icache_responder_pkg::*;
;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Hits return data in the same cycle; a miss fetches the word through the
// arbiter and the datapath re-looks up the cycle after the fill lands.
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-high reset
//   cif         datapath + arbiter buses (slave modport)
//   hit_count   saturating count of IDLE cycles with ihit=1
//   miss_count  saturating count of IDLE->FILL transitions
//   dbg_state   1 while a fill is outstanding (FILL), 0 in IDLE
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_responder_if.slave cif,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             dbg_state
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} icache_state_t;

  icache_state_t   state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_arr  [SETS];
  word_t           data_arr [SETS];

  logic            iren_q;
  word_t           miss_addr;

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            hit;
  logic            fill_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign req_idx  = cif.imemaddr[1+IW:2];
  assign req_tag  = cif.imemaddr[31:2+IW];
  assign fill_idx = miss_addr[1+IW:2];
  assign fill_tag = miss_addr[31:2+IW];

  // Lookup only counts in IDLE; during FILL the datapath sees no hit even on
  // the cycle the fill data arrives.
  assign hit       = (state == IDLE) && cif.imemREN && valid[req_idx] &&
                     (tag_arr[req_idx] == req_tag);
  assign fill_done = (state == FILL) && !cif.iwait;

  assign cif.ihit     = hit;
  assign cif.imemload = hit ? data_arr[req_idx] : '0;
  assign cif.iREN     = iren_q;
  // iaddr is only meaningful while a fill is pending.
  assign cif.iaddr    = iren_q ? miss_addr : '0;
  assign dbg_state    = (state == FILL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      iren_q     <= 1'b0;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            hit_count <= sat_inc(hit_count);
          end else if (cif.imemREN) begin
            miss_addr  <= {cif.imemaddr[31:2], 2'b00};
            iren_q     <= 1'b1;
            miss_count <= sat_inc(miss_count);
            state      <= FILL;
          end
        end
        FILL: begin
          // The fill always finishes for the latched address; imemREN and
          // imemaddr are ignored until we are back in IDLE.
          if (!cif.iwait) begin
            valid[fill_idx] <= 1'b1;
            iren_q          <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data frames carry no reset; valid bits alone gate their use. A reset
  // forces state to IDLE, so no write can happen while RST is asserted.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= cif.iload;
    end
  end

endmodule
